// File: rtl/id_2ri14_pipe.sv
// Registered multi-lane decode stage for LoongArch 2RI14 instructions (LL.W, SC.W, CSRRD/CSRWR/CSRXCHG).
// A CSR write ends the consumed group and blocks further loads until csr_done reports it retired.
module id_2ri14_pipe #(
  parameter int ISSUE_WIDTH = 2,
  parameter bit ENABLE_LLSC = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ISSUE_WIDTH-1:0]           in_valid,
  input  logic [32*ISSUE_WIDTH-1:0]        in_pc,
  input  logic [32*ISSUE_WIDTH-1:0]        in_inst,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0] in_consumed,
  input  logic                             flush,
  input  logic                             csr_done,
  input  logic                             out_ready,
  output logic [ISSUE_WIDTH-1:0]           out_valid,
  output logic [32*ISSUE_WIDTH-1:0]        out_pc,
  output logic [32*ISSUE_WIDTH-1:0]        out_inst,
  output logic [ISSUE_WIDTH-1:0]           out_inst_valid,
  output logic [ISSUE_WIDTH-1:0]           out_exc_ine,
  output logic [8*ISSUE_WIDTH-1:0]         out_aluop,
  output logic [3*ISSUE_WIDTH-1:0]         out_alusel,
  output logic [32*ISSUE_WIDTH-1:0]        out_imm,
  output logic [ISSUE_WIDTH-1:0]           out_reg1_en,
  output logic [ISSUE_WIDTH-1:0]           out_reg2_en,
  output logic [ISSUE_WIDTH-1:0]           out_rd_en,
  output logic [5*ISSUE_WIDTH-1:0]         out_reg1_addr,
  output logic [5*ISSUE_WIDTH-1:0]         out_reg2_addr,
  output logic [5*ISSUE_WIDTH-1:0]         out_rd_addr,
  output logic [ISSUE_WIDTH-1:0]           out_csr_re,
  output logic [ISSUE_WIDTH-1:0]           out_csr_we,
  output logic [ISSUE_WIDTH-1:0]           out_is_priv,
  output logic [14*ISSUE_WIDTH-1:0]        out_csr_addr,
  output logic                             busy_csr
);

  localparam int CW = $clog2(ISSUE_WIDTH+1);

  localparam logic [7:0]  LLW_OPCODE = 8'h20;
  localparam logic [7:0]  SCW_OPCODE = 8'h21;
  localparam logic [7:0]  CSR_OPCODE = 8'h04;
  localparam logic [13:0] CSR_LLBCTL = 14'h060;

  localparam logic [7:0]  ALU_NOP     = 8'h00;
  localparam logic [7:0]  ALU_LLW     = 8'h24;
  localparam logic [7:0]  ALU_SCW     = 8'h25;
  localparam logic [7:0]  ALU_CSRRD   = 8'h60;
  localparam logic [7:0]  ALU_CSRWR   = 8'h61;
  localparam logic [7:0]  ALU_CSRXCHG = 8'h62;

  localparam logic [2:0]  ALU_SEL_NOP        = 3'd0;
  localparam logic [2:0]  ALU_SEL_CSR        = 3'd6;
  localparam logic [2:0]  ALU_SEL_LOAD_STORE = 3'd7;

  typedef struct packed {
    logic        inst_valid;
    logic        exc_ine;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic        reg1_en;
    logic [4:0]  reg1_addr;
    logic        reg2_en;
    logic [4:0]  reg2_addr;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        csr_re;
    logic        csr_we;
    logic        is_priv;
    logic [13:0] csr_addr;
  } dec_t;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_CSR = 1'b1
  } state_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [4:0] rj;
    logic [4:0] rd;
    logic [13:0] si14;
    rj   = inst[9:5];
    rd   = inst[4:0];
    si14 = inst[23:10];
    d         = '0;
    d.aluop   = ALU_NOP;
    d.alusel  = ALU_SEL_NOP;
    d.exc_ine = 1'b1;
    case (inst[31:24])
      LLW_OPCODE, SCW_OPCODE: begin
        if (ENABLE_LLSC) begin
          d.inst_valid = 1'b1;
          d.exc_ine    = 1'b0;
          d.alusel     = ALU_SEL_LOAD_STORE;
          d.aluop      = (inst[31:24] == SCW_OPCODE) ? ALU_SCW : ALU_LLW;
          d.imm        = {{16{si14[13]}}, si14, 2'b00};
          d.reg1_en    = 1'b1;
          d.reg1_addr  = rj;
          d.rd_en      = 1'b1;
          d.rd_addr    = rd;
          d.csr_re     = 1'b1;
          d.csr_addr   = CSR_LLBCTL;
          if (inst[31:24] == SCW_OPCODE) begin
            d.reg2_en   = 1'b1;
            d.reg2_addr = rd;
          end
        end
      end
      CSR_OPCODE: begin
        d.inst_valid = 1'b1;
        d.exc_ine    = 1'b0;
        d.is_priv    = 1'b1;
        d.csr_addr   = si14;
        d.csr_re     = 1'b1;
        d.rd_en      = 1'b1;
        d.rd_addr    = rd;
        d.alusel     = ALU_SEL_CSR;
        // rj selects the flavour: 0 reads only, 1 writes rd, otherwise rj is the write mask.
        if (rj == 5'd0) begin
          d.aluop = ALU_CSRRD;
        end else if (rj == 5'd1) begin
          d.aluop     = ALU_CSRWR;
          d.reg1_en   = 1'b1;
          d.reg1_addr = rd;
          d.csr_we    = 1'b1;
        end else begin
          d.aluop     = ALU_CSRXCHG;
          d.reg1_en   = 1'b1;
          d.reg1_addr = rd;
          d.reg2_en   = 1'b1;
          d.reg2_addr = rj;
          d.csr_we    = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  dec_t   [ISSUE_WIDTH-1:0] w_dec;
  logic   [ISSUE_WIDTH-1:0] w_take_mask;
  logic   [CW-1:0]          w_take_cnt;
  logic                     w_take_csrw;
  logic                     w_stop;
  logic                     w_load;

  state_t                        r_state;
  logic                          r_busy_csr;
  logic [ISSUE_WIDTH-1:0]        r_out_valid;
  logic [ISSUE_WIDTH-1:0][31:0]  r_pc;
  logic [ISSUE_WIDTH-1:0][31:0]  r_inst;
  dec_t [ISSUE_WIDTH-1:0]        r_dec;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_dec
    assign w_dec[g] = decode(in_inst[32*g +: 32]);
  end

  // Take lanes from 0 upward; stop at the first hole or right after the first CSR write.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    w_take_mask = '0;
    w_take_cnt  = '0;
    w_take_csrw = 1'b0;
    w_stop      = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!w_stop && in_valid[i]) begin
        w_take_mask[i] = 1'b1;
        w_take_cnt     = w_take_cnt + CW'(1);
        if (w_dec[i].csr_we) begin
          w_take_csrw = 1'b1;
          w_stop      = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign w_load      = (r_state == S_IDLE) && !flush && ((r_out_valid == '0) || out_ready);
  assign in_consumed = (rst_n && w_load) ? w_take_cnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload registers are reset too, so every out_* port reads 0 during and after reset.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy_csr  <= 1'b0;
      r_out_valid <= '0;
      r_pc        <= '0;
      r_inst      <= '0;
      r_dec       <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= S_IDLE;
      r_busy_csr  <= 1'b0;
      r_out_valid <= '0;
    end else if (w_load) begin
      r_out_valid <= w_take_mask;
      r_pc        <= in_pc;
      r_inst      <= in_inst;
      r_dec       <= w_dec;
      if (w_take_csrw) begin
        r_state    <= S_WAIT_CSR;
        r_busy_csr <= 1'b1;
      end
    end else begin
      if (out_ready) begin
        r_out_valid <= '0;
      end
      if (r_state == S_WAIT_CSR && csr_done) begin
        r_state    <= S_IDLE;
        r_busy_csr <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_pc;
  assign out_inst  = r_inst;
  assign busy_csr  = r_busy_csr;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_out
    assign out_inst_valid[g]       = r_dec[g].inst_valid;
    assign out_exc_ine[g]          = r_dec[g].exc_ine;
    assign out_aluop[8*g +: 8]     = r_dec[g].aluop;
    assign out_alusel[3*g +: 3]    = r_dec[g].alusel;
    assign out_imm[32*g +: 32]     = r_dec[g].imm;
    assign out_reg1_en[g]          = r_dec[g].reg1_en;
    assign out_reg2_en[g]          = r_dec[g].reg2_en;
    assign out_rd_en[g]            = r_dec[g].rd_en;
    assign out_reg1_addr[5*g +: 5] = r_dec[g].reg1_addr;
    assign out_reg2_addr[5*g +: 5] = r_dec[g].reg2_addr;
    assign out_rd_addr[5*g +: 5]   = r_dec[g].rd_addr;
    assign out_csr_re[g]           = r_dec[g].csr_re;
    assign out_csr_we[g]           = r_dec[g].csr_we;
    assign out_is_priv[g]          = r_dec[g].is_priv;
    assign out_csr_addr[14*g +: 14] = r_dec[g].csr_addr;
  end

endmodule

// File: doc/id_2ri14_pipe.md
Name: id_2ri14_pipe

Overview:
- Registered, multi-lane decode stage for LoongArch 2RI14-format instructions: LL.W, SC.W, CSRRD, CSRWR, CSRXCHG.
- Sits between the instruction buffer and dispatch.
- Decodes up to ISSUE_WIDTH instructions per cycle into one output pipeline register, under a valid/ready handshake.
- Serialises CSR writes: no instruction after a CSR write is consumed until the backend signals that write retired.

Parameters:
- ISSUE_WIDTH, 2, number of decode lanes (1..4).
- ENABLE_LLSC, 1, when 0, LL.W/SC.W decode as illegal (INE).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  ISSUE_WIDTH  per-lane valid; contiguous from lane 0
- in_pc  in  32*ISSUE_WIDTH  lane PCs
- in_inst  in  32*ISSUE_WIDTH  lane instruction words
- in_consumed  out  $clog2(ISSUE_WIDTH+1)  lanes taken this cycle (combinational); upstream pops this many
- flush  in  1  pipeline flush
- csr_done  in  1  single-cycle pulse: serialised CSR write retired
- out_ready  in  1  dispatch accepts the bundle
- out_valid  out  ISSUE_WIDTH  per-lane valid
- out_pc, out_inst  out  32*ISSUE_WIDTH  pass-through
- out_inst_valid  out  ISSUE_WIDTH  legal 2RI14 instruction
- out_exc_ine  out  ISSUE_WIDTH  illegal-instruction exception
- out_aluop  out  8*ISSUE_WIDTH  decoded ALU op
- out_alusel  out  3*ISSUE_WIDTH  decoded ALU select
- out_imm  out  32*ISSUE_WIDTH  immediate
- out_reg1_en, out_reg2_en, out_rd_en  out  ISSUE_WIDTH each  source-1 read, source-2 read, destination write enables
- out_reg1_addr, out_reg2_addr, out_rd_addr  out  5*ISSUE_WIDTH each  register addresses
- out_csr_re, out_csr_we, out_is_priv  out  ISSUE_WIDTH each  CSR read enable, CSR write enable, privileged
- out_csr_addr  out  14*ISSUE_WIDTH  CSR number
- busy_csr  out  1  FSM in WAIT_CSR

Behaviour:
- Field extraction: opcode=inst[31:24], si14/csr=inst[23:10], rj=inst[9:5], rd=inst[4:0].
- `LLW_OPCODE: rd_en=1, reg1=rj, csr_re=1, csr_addr=`CSR_LLBCTL, aluop `ALU_LLW, alusel `ALU_SEL_LOAD_STORE, imm=sext(si14)<<2.
- `SCW_OPCODE: as LL.W but aluop `ALU_SCW, plus reg2=rd.
- `CSR_OPCODE: is_priv=1, csr_addr=csr, imm=0, csr_re=1, rd_en=1, alusel `ALU_SEL_CSR.
  - rj=0: CSRRD, no GPR reads.
  - rj=1: CSRWR, reg1=rd, csr_we=1.
  - else: CSRXCHG, reg1=rd, reg2=rj, csr_we=1.
- Any other opcode, or LL/SC with ENABLE_LLSC=0: inst_valid=0, exc_ine=1, all enables 0, aluop `ALU_NOP, alusel `ALU_SEL_NOP. The lane is still consumed and output.
- Unused address/imm fields are 0.
- FSM states: IDLE, WAIT_CSR.
- load = state==IDLE && !flush && (out_valid==0 || out_ready).
- in_consumed when load: count of valid lanes up to and including the first lane decoding to CSRWR/CSRXCHG; all valid lanes if none. Otherwise 0.
- Lanes after the CSR write stay upstream and are re-presented later at lane 0.
- On load (clock edge): out_valid[i]=1 for consumed lanes, 0 for the rest. Decoded fields are registered; latency 1 cycle.
- If the loaded bundle holds a CSR write: state -> WAIT_CSR.
- If !load && out_ready: out_valid cleared.
- If out_valid!=0 && !out_ready: all outputs held stable.
- WAIT_CSR: in_consumed=0. On csr_done -> IDLE; loading resumes the following cycle. csr_done in IDLE is ignored.
- flush: out_valid cleared, state -> IDLE, in_consumed=0 that cycle. Flush wins over simultaneous csr_done and load.
- Reset (async, any time, including WAIT_CSR or stalled output): state IDLE, all out_* registers 0, busy_csr 0.
- in_consumed is combinational and equals 0 while rst_n=0.
- in_valid holes (lane i valid, lane i-1 invalid) are illegal input; only lanes below the first hole are consumed.

Test Plan:
- W=2, lanes {CSRRD csr=0x005 rd=4, LL.W rj=3 rd=5 si14=0x3FFF}, out_ready=1 -> in_consumed=2. Next cycle: lane0 csr_addr=0x005, rd_addr=4; lane1 imm=0xFFFFFFFC, csr_addr=`CSR_LLBCTL.
- W=2, {CSRWR rd=7 csr=0x0C, SC.W}. Required sequence:
  - in_consumed=1, busy_csr=1, in_consumed stays 0.
  - Pulse csr_done at cycle 5 -> cycle 6 SC.W consumed at lane 0 with reg1=rj, reg2=rd.
- out_ready=0 for 3 cycles with valid bundle -> outputs bit-identical and in_consumed=0 throughout; out_ready=1 -> next bundle loads.
- inst=0xFFFFFFFF -> out_inst_valid=0, out_exc_ine=1, aluop `ALU_NOP.
- ENABLE_LLSC=0 with LL.W -> out_exc_ine=1.
- flush asserted together with csr_done in WAIT_CSR -> out_valid=0, state IDLE, in_consumed=0; load resumes the following cycle.
- rst_n dropped mid-cycle while WAIT_CSR and output stalled -> immediately out_valid=0, busy_csr=0; after release, first bundle loads normally.
